// File: rtl/timer_dev.sv
// -----------------------------------------------------------------------------
// timer_dev
//
// Programmable down-counting timer. It sits behind the system bridge as device 0
// and provides a one-shot mode and an auto-reload mode, plus a maskable
// interrupt.
//
// Register map (word offset on Addr):
//   0  CTRL    [0] EN, [2:1] MODE (01 auto-reload, anything else one-shot),
//              [3] IM. Upper bits read as zero.
//   1  PRESET  Reload value, CNT_WIDTH bits wide. Read/write.
//   2  COUNT   Current count value. Read-only; writes are ignored.
//   3  STATUS  Exists only when TIMER_STATUS_EN is defined.
//              [0] irq_flag (write 1 to clear), [15:8] completed countdowns.
//              Without the macro, reads return 0 and writes are ignored.
//
// Optional feature macro: TIMER_STATUS_EN
//
// Ports:
//   clk    system clock; all state updates on the rising edge
//   reset  asynchronous, active-high; clears all state immediately
//   Addr   register word offset
//   WE     write strobe, sampled on the clock edge
//   BE     byte enables for writes; BE[i] gates WD[8i+7:8i]
//   WD     write data
//   RD     read data, combinational from Addr
//   IRQ    interrupt request = irq_flag & CTRL.IM
// -----------------------------------------------------------------------------
module timer_dev #(
    parameter int CNT_WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [3:0]  BE,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_EN = 0;
    localparam int CTRL_IM = 3;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    // Merge new write data into an old 32-bit value one byte lane at a time.
    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  be
    );
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

    state_t               state_q,    state_d;
    logic [3:0]           ctrl_q,     ctrl_d;
    logic [CNT_WIDTH-1:0] preset_q,   preset_d;
    logic [CNT_WIDTH-1:0] count_q,    count_d;
    logic                 irq_flag_q, irq_flag_d;
    logic                 irq_q,      irq_d;
`ifdef TIMER_STATUS_EN
    logic [7:0]           done_cnt_q, done_cnt_d;
    logic                 wr_status_s;
`endif

    logic        wr_ctrl_s;
    logic        wr_preset_s;
    logic        auto_reload_s;
    logic        flag_set_s;
    logic        flag_hw_clr_s;
    logic        flag_sw_clr_s;
    logic        en_hw_clr_s;
    logic [31:0] preset_ext_s;
    logic [31:0] count_ext_s;
    logic [31:0] preset_merged_s;

    assign wr_ctrl_s     = WE && (Addr == ADDR_CTRL);
    assign wr_preset_s   = WE && (Addr == ADDR_PRESET);
    assign auto_reload_s = (ctrl_q[2:1] == 2'b01);
`ifdef TIMER_STATUS_EN
    assign wr_status_s   = WE && (Addr == ADDR_STATUS);
    // Only an explicit write-one to STATUS bit 0 clears the flag.
    assign flag_sw_clr_s = wr_status_s && BE[0] && WD[0];
`else
    // Any CTRL or PRESET access acknowledges the interrupt.
    assign flag_sw_clr_s = wr_ctrl_s || wr_preset_s;
`endif

    // Zero-extend the counter-width registers onto the 32-bit bus.
    always_comb begin
        preset_ext_s                  = 32'd0;
        count_ext_s                   = 32'd0;
        preset_ext_s[CNT_WIDTH-1:0]   = preset_q;
        count_ext_s[CNT_WIDTH-1:0]    = count_q;
    end

    // Next-state logic for the countdown FSM, registers and interrupt flag.
    always_comb begin
        state_d         = state_q;
        ctrl_d          = ctrl_q;
        preset_d        = preset_q;
        count_d         = count_q;
        irq_flag_d      = irq_flag_q;
        flag_set_s      = 1'b0;
        flag_hw_clr_s   = 1'b0;
        en_hw_clr_s     = 1'b0;
        preset_merged_s = byte_merge(preset_ext_s, WD, BE);
`ifdef TIMER_STATUS_EN
        done_cnt_d      = done_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (ctrl_q[CTRL_EN]) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q[CTRL_EN]) begin
                    // Disabled mid-count: COUNT holds its value.
                    state_d = ST_IDLE;
                end else if (count_q <= CNT_ONE) begin
                    // Covers PRESET=0 as well: it expires after one CNT cycle.
                    count_d    = CNT_ZERO;
                    flag_set_s = 1'b1;
                    state_d    = ST_INT;
                end else begin
                    count_d = count_q - CNT_ONE;
                    state_d = ST_CNT;
                end
            end
            ST_INT: begin
                if (auto_reload_s) begin
                    // Auto-reload produces a single-cycle flag pulse.
                    flag_hw_clr_s = 1'b1;
                    if (ctrl_q[CTRL_EN]) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    en_hw_clr_s = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A software write to the EN byte overrides the one-shot auto-disable.
        if (wr_ctrl_s && BE[0]) begin
            ctrl_d = WD[3:0];
        end else if (en_hw_clr_s) begin
            ctrl_d = {ctrl_q[3:1], 1'b0};
        end else begin
            ctrl_d = ctrl_q;
        end

        if (wr_preset_s) begin
            preset_d = preset_merged_s[CNT_WIDTH-1:0];
        end else begin
            preset_d = preset_q;
        end

        // Setting the flag takes priority so that a hardware event is never lost.
        if (flag_set_s) begin
            irq_flag_d = 1'b1;
        end else if (flag_hw_clr_s || flag_sw_clr_s) begin
            irq_flag_d = 1'b0;
        end else begin
            irq_flag_d = irq_flag_q;
        end

`ifdef TIMER_STATUS_EN
        if (flag_set_s) begin
            done_cnt_d = done_cnt_q + 8'd1;
        end else begin
            done_cnt_d = done_cnt_q;
        end
`endif

        // IRQ is registered from next-state values, so it matches flag & IM.
        irq_d = irq_flag_d & ctrl_d[CTRL_IM];
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= 4'd0;
            preset_q   <= CNT_ZERO;
            count_q    <= CNT_ZERO;
            irq_flag_q <= 1'b0;
            irq_q      <= 1'b0;
`ifdef TIMER_STATUS_EN
            done_cnt_q <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
            irq_q      <= irq_d;
`ifdef TIMER_STATUS_EN
            done_cnt_q <= done_cnt_d;
`endif
        end
    end

    // Zero-wait-state read mux.
    always_comb begin
        case (Addr)
            ADDR_CTRL:   RD = {28'd0, ctrl_q};
            ADDR_PRESET: RD = preset_ext_s;
            ADDR_COUNT:  RD = count_ext_s;
`ifdef TIMER_STATUS_EN
            ADDR_STATUS: RD = {16'd0, done_cnt_q, 7'd0, irq_flag_q};
`else
            ADDR_STATUS: RD = 32'd0;
`endif
            default:     RD = 32'd0;
        endcase
    end

    assign IRQ = irq_q;

endmodule
